// File: rtl/datain_sink_chk_if.sv
// Ingress flit handshake from the router ejection port into the sink checker.
interface datain_sink_chk_if;
    logic [19:0] in_data;
    logic        in_valid;
    logic        in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/datain_sink_chk.sv
// Receive-side NoC endpoint: buffers ejected flits, checks routing/format on pop,
// tracks per-source arrival and reports completion or an idle timeout.
module datain_sink_chk #(
    parameter int unsigned NODE_ID    = 0,
    parameter int unsigned NUM_NODES  = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 1023
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               hold,
    datain_sink_chk_if.slave   in_if,
    output logic [19:0]        last_flit,
    output logic               last_valid,
    output logic [7:0]         rx_count,
    output logic [7:0]         dup_count,
    output logic [7:0]         err_count,
    output logic [15:0]        src_seen,
    output logic               all_rcvd,
    output logic               timeout_flag
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    localparam logic [7:0]  NodeId8   = 8'(NODE_ID);
    localparam logic [3:0]  NodeId4   = 4'(NODE_ID);
    localparam logic [7:0]  NumNodes8 = 8'(NUM_NODES);
    localparam logic [15:0] Timeout16 = 16'(TIMEOUT);
    localparam logic [31:0] AllMask   = (32'd1 << NUM_NODES) - 32'd1;
    localparam logic [15:0] ExpMask   = AllMask[15:0] & ~(16'd1 << NODE_ID);

    typedef enum logic [1:0] {StIdle, StRun, StTout, StDone} state_e;

    state_e        state_q, state_d;
    logic [19:0]   mem_q [FIFO_DEPTH];
    logic [19:0]   mem_d [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [19:0]   last_flit_q, last_flit_d;
    logic          last_valid_q, last_valid_d;
    logic [7:0]    rx_q, rx_d;
    logic [7:0]    dup_q, dup_d;
    logic [7:0]    err_q, err_d;
    logic [15:0]   seen_q, seen_d;
    logic [15:0]   idle_q, idle_d;
    logic          tout_q, tout_d;

    logic          full, empty, push, pop, bad, all_rcvd_w;
    logic [19:0]   head;
    logic [7:0]    src;
    logic [3:0]    dest;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign in_if.in_ready = !full && !clear;
    assign push       = in_if.in_valid && !full && !clear;
    assign pop        = !empty && !hold && !clear;
    assign head       = mem_q[rd_ptr_q[AW-1:0]];
    assign src        = head[19:12];
    assign dest       = head[7:4];
    assign bad        = (dest != NodeId4) || (head[3:0] != dest) || (head[11:8] != 4'd0) ||
                        (src >= NumNodes8) || (src == NodeId8);
    assign all_rcvd_w = (seen_q == ExpMask);

    // Next-state for FIFO, flit check, stats and the completion/timeout FSM.
    always_comb begin
        state_d      = state_q;
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        last_flit_d  = last_flit_q;
        last_valid_d = 1'b0;
        rx_d         = rx_q;
        dup_d        = dup_q;
        err_d        = err_q;
        seen_d       = seen_q;
        idle_d       = idle_q;
        tout_d       = tout_q;

        if (clear) begin
            state_d     = StIdle;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            last_flit_d = '0;
            rx_d        = '0;
            dup_d       = '0;
            err_d       = '0;
            seen_d      = '0;
            idle_d      = '0;
            tout_d      = 1'b0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q[AW-1:0]] = in_if.in_data;
                wr_ptr_d                = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d     = rd_ptr_q + 1'b1;
                last_flit_d  = head;
                last_valid_d = 1'b1;
                if (bad) begin
                    if (err_q != 8'hFF) err_d = err_q + 8'd1;
                end else if (seen_q[src[3:0]]) begin
                    if (dup_q != 8'hFF) dup_d = dup_q + 8'd1;
                end else begin
                    seen_d[src[3:0]] = 1'b1;
                    if (rx_q != 8'hFF) rx_d = rx_q + 8'd1;
                end
            end

            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        state_d = StRun;
                        idle_d  = '0;
                    end
                end
                StRun: begin
                    if (all_rcvd_w) begin
                        state_d = StDone;
                    end else if (pop) begin
                        idle_d = '0;
                    end else if (idle_q + 16'd1 >= Timeout16) begin
                        state_d = StTout;
                        tout_d  = 1'b1;
                    end else begin
                        idle_d = idle_q + 16'd1;
                    end
                end
                StTout: begin
                    if (all_rcvd_w) state_d = StDone;
                end
                StDone: ;
                default: state_d = StIdle;
            endcase
        end
    end

    // State registers; reset discards anything still buffered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            mem_q        <= '{default: '0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            last_flit_q  <= '0;
            last_valid_q <= 1'b0;
            rx_q         <= '0;
            dup_q        <= '0;
            err_q        <= '0;
            seen_q       <= '0;
            idle_q       <= '0;
            tout_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            last_flit_q  <= last_flit_d;
            last_valid_q <= last_valid_d;
            rx_q         <= rx_d;
            dup_q        <= dup_d;
            err_q        <= err_d;
            seen_q       <= seen_d;
            idle_q       <= idle_d;
            tout_q       <= tout_d;
        end
    end

    assign last_flit    = last_flit_q;
    assign last_valid   = last_valid_q;
    assign rx_count     = rx_q;
    assign dup_count    = dup_q;
    assign err_count    = err_q;
    assign src_seen     = seen_q;
    assign all_rcvd     = all_rcvd_w;
    assign timeout_flag = tout_q;

endmodule

// File: tb/tb_datain_sink_chk.sv
// Directed bench for datain_sink_chk with NODE_ID=2, NUM_NODES=16, FIFO_DEPTH=4, TIMEOUT=20.
module tb_datain_sink_chk;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clear = 1'b0;
    logic        hold = 1'b0;
    logic [19:0] last_flit;
    logic        last_valid;
    logic [7:0]  rx_count, dup_count, err_count;
    logic [15:0] src_seen;
    logic        all_rcvd, timeout_flag;

    int n_vec = 0;
    int n_err = 0;

    datain_sink_chk_if d_if ();

    datain_sink_chk #(
        .NODE_ID    (2),
        .NUM_NODES  (16),
        .FIFO_DEPTH (4),
        .TIMEOUT    (20)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .hold         (hold),
        .in_if        (d_if),
        .last_flit    (last_flit),
        .last_valid   (last_valid),
        .rx_count     (rx_count),
        .dup_count    (dup_count),
        .err_count    (err_count),
        .src_seen     (src_seen),
        .all_rcvd     (all_rcvd),
        .timeout_flag (timeout_flag)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offer one flit for one edge, then sample just after the pop edge.
    task automatic send(input logic [19:0] f);
        d_if.in_data  = f;
        d_if.in_valid = 1'b1;
        @(posedge clk); #1;
        d_if.in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [19:0] hold_flits [6];

    initial begin
        hold_flits = '{20'h00022, 20'h01022, 20'h03022, 20'h04022, 20'h05022, 20'h06022};
        d_if.in_data  = '0;
        d_if.in_valid = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(1);

        // Reset state
        check_val("rst_ready",  32'(d_if.in_ready), 32'd1);
        check_val("rst_lflit",  32'(last_flit), 32'h0);
        check_val("rst_lvalid", 32'(last_valid), 32'd0);
        check_val("rst_rx",     32'(rx_count), 32'd0);
        check_val("rst_seen",   32'(src_seen), 32'h0);
        check_val("rst_all",    32'(all_rcvd), 32'd0);
        check_val("rst_tout",   32'(timeout_flag), 32'd0);

        // 1: first good flit from source 14
        send(20'h0E022);
        check_val("t1_lflit",  32'(last_flit), 32'h0E022);
        check_val("t1_lvalid", 32'(last_valid), 32'd1);
        check_val("t1_rx",     32'(rx_count), 32'd1);
        check_val("t1_seen",   32'(src_seen), 32'h4000);

        // 2: duplicate and the three error kinds
        send(20'h0E022);
        check_val("t2_dup", 32'(dup_count), 32'd1);
        check_val("t2_rx",  32'(rx_count), 32'd1);
        send(20'h0E033);
        check_val("t2_err_dest", 32'(err_count), 32'd1);
        send(20'h02022);
        check_val("t2_err_self", 32'(err_count), 32'd2);
        send(20'h0E023);
        check_val("t2_err_chk",  32'(err_count), 32'd3);
        check_val("t2_lflit",    32'(last_flit), 32'h0E023);
        tick(1);
        check_val("t2_lvalid_off", 32'(last_valid), 32'd0);

        // 3: hold fills the FIFO, extra offers are refused, then drain back-to-back
        hold = 1'b1;
        d_if.in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            d_if.in_data = hold_flits[i];
            tick(1);
            check_val($sformatf("t3_ready%0d", i), 32'(d_if.in_ready), (i < 3) ? 32'd1 : 32'd0);
        end
        d_if.in_valid = 1'b0;
        hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check_val($sformatf("t3_pop%0d", i), 32'(last_flit), 32'(hold_flits[i]));
            check_val($sformatf("t3_pv%0d", i), 32'(last_valid), 32'd1);
            if (i == 0) check_val("t3_ready_after_pop", 32'(d_if.in_ready), 32'd1);
        end
        tick(1);
        check_val("t3_drained", 32'(last_valid), 32'd0);
        check_val("t3_rx",      32'(rx_count), 32'd5);
        check_val("t3_seen",    32'(src_seen), 32'h401B);

        // 4: remaining sources complete the set
        for (int s = 5; s < 16; s++) begin
            if (s != 14) send({8'(s), 12'h022});
        end
        check_val("t4_all",  32'(all_rcvd), 32'd1);
        check_val("t4_seen", 32'(src_seen), 32'hFFFB);
        check_val("t4_rx",   32'(rx_count), 32'd15);
        check_val("t4_dup",  32'(dup_count), 32'd1);
        check_val("t4_tout", 32'(timeout_flag), 32'd0);

        // 5: clear, one flit, then idle until the timeout boundary
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check_val("t5_clr_rx",   32'(rx_count), 32'd0);
        check_val("t5_clr_all",  32'(all_rcvd), 32'd0);
        send(20'h00022);
        tick(19);
        check_val("t5_tout_pre", 32'(timeout_flag), 32'd0);
        tick(1);
        check_val("t5_tout",     32'(timeout_flag), 32'd1);
        for (int s = 1; s < 16; s++) begin
            if (s != 2) send({8'(s), 12'h022});
        end
        check_val("t5_all",       32'(all_rcvd), 32'd1);
        check_val("t5_rx",        32'(rx_count), 32'd15);
        check_val("t5_tout_kept", 32'(timeout_flag), 32'd1);

        // 6: error counter saturation, clear over a live offer, async reset
        d_if.in_data  = 20'h0E033;
        d_if.in_valid = 1'b1;
        tick(300);
        d_if.in_valid = 1'b0;
        tick(2);
        check_val("t6_err_sat", 32'(err_count), 32'd255);
        check_val("t6_rx_kept", 32'(rx_count), 32'd15);
        clear = 1'b1;
        d_if.in_data  = 20'h00022;
        d_if.in_valid = 1'b1;
        #1;
        check_val("t6_ready_clr", 32'(d_if.in_ready), 32'd0);
        @(posedge clk); #1;
        clear = 1'b0;
        d_if.in_valid = 1'b0;
        check_val("t6_clr_err",  32'(err_count), 32'd0);
        check_val("t6_clr_seen", 32'(src_seen), 32'h0);
        check_val("t6_clr_tout", 32'(timeout_flag), 32'd0);
        check_val("t6_clr_lf",   32'(last_flit), 32'h0);
        tick(1);
        check_val("t6_dropped_lv", 32'(last_valid), 32'd0);
        check_val("t6_dropped_rx", 32'(rx_count), 32'd0);

        d_if.in_data  = 20'h01022;
        d_if.in_valid = 1'b1;
        tick(3);
        check_val("t6_pre_rst_rx", 32'(rx_count), 32'd1);
        #3 rst = 1'b0;
        #1;
        check_val("t6_arst_rx",   32'(rx_count), 32'd0);
        check_val("t6_arst_dup",  32'(dup_count), 32'd0);
        check_val("t6_arst_lf",   32'(last_flit), 32'h0);
        check_val("t6_arst_lv",   32'(last_valid), 32'd0);
        check_val("t6_arst_seen", 32'(src_seen), 32'h0);
        d_if.in_valid = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(1);
        check_val("t6_fifo_flushed", 32'(last_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
